uart_rcv: RTL and testbench
===========================

# uart_rcv

Serial receiver that sits at the far end of the transmit line driven by the serial transmitter. It converts an 8N1 asynchronous stream (start bit 0, eight data bits LSB first, stop bit 1) back into bytes. It presents each byte with a full/read handshake to the bus-side register interface. The bit period matches the transmitter, so a transmitter/receiver pair is loopback-compatible.

## Interface
- BIT_CYCLES, 1303: clock cycles per bit; matches the transmitter's 1302-down-to-0 reload.
- HALF_CYCLES, 651: cycles from start-edge detection to the start-bit sample point.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- serial_in  input  1  raw line from the pin; idle high; asynchronous to clk.
- read  input  1  consumer acknowledges parallel_out; effective only while full=1.
- full  output  1  parallel_out holds an unread byte; reset 0.
- parallel_out  output  8  last received byte; reset 8'h00.
- frame_err  output  1  last frame had stop bit 0; reset 0.
- overrun  output  1  a byte arrived while full=1 and was not read; reset 0.

## Operation
- Input path:
  - Two-flop synchronizer on serial_in, both flops reset to 1.
  - "rx" below means the synchronized value, or the filtered value when the majority filter is enabled (see Configuration).
- Bit counter:
  - 11 bits, counts down.
  - Reloads with HALF_CYCLES-1 or BIT_CYCLES-1.
  - A sample happens in the cycle where the counter equals 0.
- State machine (shared enum):
  - IDLE: on rx=0 -> START, counter=HALF_CYCLES-1.
  - START: at sample, rx=1 -> IDLE (false start, nothing flagged). rx=0 -> DATA, bit index=0, counter=BIT_CYCLES-1.
  - DATA: at sample, shift <= {rx, shift[7:1]} and index++. After the 8th sample -> STOP, counter=BIT_CYCLES-1.
  - STOP, sample rx=1: parallel_out<=shift, full<=1, frame_err<=0. Set overrun<=1 if full was 1 and read is 0 in that cycle. Then -> IDLE.
  - STOP, sample rx=0: frame_err<=1; byte discarded; full, parallel_out and overrun unchanged. -> BREAK.
  - BREAK: wait for rx=1, then -> IDLE. A held-low line (break) produces exactly one frame_err and no further frames.
- Handshake:
  - read while full=1: full<=0 and overrun<=0 in the next cycle.
  - read while full=0: ignored.
- Simultaneous read and good stop sample: the new byte loads, full stays 1, overrun is not set.
- Overrun policy: the new byte overwrites parallel_out.
- Reset mid-frame: all state returns to reset values immediately. The synchronizer is forced to 1, so a line still low after reset release is treated as a fresh start edge.

## Timing
- t0 = first IDLE cycle with rx=0; that is two clocks after the pin edge, or three with the filter enabled.
- Sample points:
  - start bit: t0+HALF_CYCLES.
  - data bit i: t0+HALF_CYCLES+(i+1)*BIT_CYCLES.
  - stop bit: t0+HALF_CYCLES+9*BIT_CYCLES; defaults give t0+12378.
- full, parallel_out, frame_err and overrun update in the cycle after the stop sample.
- IDLE is re-entered in the same cycle, so back-to-back frames with zero idle time are received.
- read to full=0: one cycle.

## Configuration
- UART_RCV_MAJORITY_EN defined:
  - rx is the 2-of-3 majority of the last three synchronized samples.
  - This applies to start detection and to every bit sample.
  - It adds one cycle to the path from pin to t0.
- UART_RCV_MAJORITY_EN undefined: rx is the plain synchronizer output.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - the default BIT_CYCLES/HALF_CYCLES constants, shared with the transmitter;
  - the counter width of 11.
- Sub-module uart_rcv_sync: synchronizer plus the optional majority filter. Output rx, reset value 1.
- The FSM, counter, shift register and handshake flags stay in uart_rcv.

## Test plan
- Drive byte 8'hA5 at 1303 cycles/bit -> full=1 at stop sample+1, parallel_out=8'hA5, frame_err=0, overrun=0.
- 300-cycle low glitch on an idle line -> START aborts, returns to IDLE, full stays 0, no flags.
- Frame 8'h3C with stop bit 0, then line held low 5000 cycles -> one frame_err=1, full=0, no second frame until the line is high.
- Bytes 8'h11 then 8'h22 with no read -> full=1, parallel_out=8'h22, overrun=1. A subsequent read clears full and overrun.
- read asserted in the exact cycle of the 8'h22 stop sample while 8'h11 is held -> parallel_out=8'h22, full=1, overrun=0.
- Loopback from the transmitter, bytes 00/FF/55 back-to-back -> all three received intact. Reset mid-second byte -> all outputs at reset values next cycle, and the third byte is received correctly after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared UART types and constants for the serial transmitter/receiver pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Clock cycles per serial bit; the transmitter reloads 1302 down to 0.
    localparam int BIT_CYCLES  = 1303;
    // Cycles from start-edge detection to the middle of the start bit.
    localparam int HALF_CYCLES = 651;
    // Width of the bit-timing down-counter.
    localparam int CNT_W       = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rcv_state_t;

endpackage

// File: rtl/uart_rcv_if.sv
// Purpose: serial line plus byte/handshake bundle between the receiver and its bus-side consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer pulses read while full=1; unread bytes are overwritten and flagged as overrun.
interface uart_rcv_if;
    logic       serial_in;
    logic       read;
    logic       full;
    logic [7:0] parallel_out;
    logic       frame_err;
    logic       overrun;

    // Receiver side: takes the line and read, drives the byte and status flags.
    modport master (
        input  serial_in,
        input  read,
        output full,
        output parallel_out,
        output frame_err,
        output overrun
    );

    // Consumer side (and line driver in a testbench).
    modport slave (
        output serial_in,
        output read,
        input  full,
        input  parallel_out,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rcv_sync.sv
// Purpose: two-flop synchronizer for the raw serial line, with optional 2-of-3 majority filter (UART_RCV_MAJORITY_EN).
// Latency: two clocks pin-to-rx, three with the majority filter.
// Backpressure: none; free-running, rx idles and resets to 1.
module uart_rcv_sync (
    input  logic clk,
    input  logic reset,
    input  logic serial_in,
    output logic rx
);

    logic meta_q;
    logic sync_q;

    // Two-stage synchronizer; both stages reset to the idle-line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= serial_in;
            sync_q <= meta_q;
        end
    end

`ifdef UART_RCV_MAJORITY_EN
    logic hist1_q;
    logic hist2_q;

    // Keep the two previous synchronized samples for the majority vote.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= sync_q;
            hist2_q <= hist1_q;
        end
    end

    // A single-cycle spike cannot flip rx; a real edge shows up one clock later.
    assign rx = (sync_q & hist1_q) | (sync_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign rx = sync_q;
`endif

endmodule

// File: rtl/uart_rcv.sv
// Purpose: 8N1 serial receiver presenting bytes with a full/read handshake (majority filter via UART_RCV_MAJORITY_EN).
// Latency: outputs update one clock after the stop-bit sample; read clears full one clock later.
// Backpressure: none on the line; an unread byte is overwritten and overrun is raised.
module uart_rcv
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    uart_rcv_if.master bus
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);

    logic rx;

    uart_rcv_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .serial_in (bus.serial_in),
        .rx        (rx)
    );

    rcv_state_t       state_q;
    rcv_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             full_q;
    logic             frame_err_q;
    logic             overrun_q;

    logic sample;
    logic load_half;
    logic load_bit;
    logic shift_en;
    logic byte_ok;
    logic byte_bad;

    assign sample = (cnt_q == '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: sample points come from the down-counter reaching zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx) state_d = START;
            START:   if (sample) state_d = rx ? IDLE : DATA;
            DATA:    if (sample && (idx_q == 3'd7)) state_d = STOP;
            STOP:    if (sample) state_d = rx ? IDLE : BREAK;
            BREAK:   if (rx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes for the counter, shifter and output flags.
    always_comb begin
        load_half = 1'b0;
        load_bit  = 1'b0;
        shift_en  = 1'b0;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        case (state_q)
            IDLE:  load_half = !rx;
            START: load_bit  = sample && !rx;
            DATA: begin
                shift_en = sample;
                load_bit = sample;
            end
            STOP: begin
                byte_ok  = sample && rx;
                byte_bad = sample && !rx;
            end
            default: ;
        endcase
    end

    // Bit timing counter; parks at zero when nothing is being timed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_half) begin
            cnt_q <= HALF_LOAD;
        end else if (load_bit) begin
            cnt_q <= BIT_LOAD;
        end else if (!sample) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Data shifter, LSB arrives first; bit index restarts outside DATA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
        end else if (shift_en) begin
            shift_q <= {rx, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
        end else if (state_q != DATA) begin
            idx_q   <= 3'd0;
        end
    end

    // Byte hand-off and status flags; a good stop beats a same-cycle read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_q      <= 8'h00;
            full_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (byte_ok) begin
            byte_q      <= shift_q;
            full_q      <= 1'b1;
            frame_err_q <= 1'b0;
            if (full_q) begin
                overrun_q <= !bus.read;
            end
        end else begin
            if (byte_bad) begin
                frame_err_q <= 1'b1;
            end
            if (bus.read && full_q) begin
                full_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.full         = full_q;
    assign bus.parallel_out = byte_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Purpose: directed self-checking bench for uart_rcv with hand-computed expectations.
// Latency: checks the stop-sample cycle and the cycle after it for every frame.
// Backpressure: exercises unread bytes (overrun), read on the stop sample and read while empty.
module tb_uart_rcv;
    import uart_pkg::*;

`ifdef UART_RCV_MAJORITY_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 2;
`endif
    // Pin-edge to stop-sample distance and full frame length, in clocks.
    localparam int STOP_SAMPLE = SYNC_LAT + HALF_CYCLES + 9 * BIT_CYCLES;
    localparam int FRAME       = 10 * BIT_CYCLES;
    localparam int FRAME_REST  = FRAME - STOP_SAMPLE - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_rcv_if bus_if ();

    uart_rcv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input rcv_state_t exp);
        checks++;
        assert (dut.state_q === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, dut.state_q, exp);
        end
    endtask

    // Drive start, data and stop bits, returning in the receiver's stop-sample cycle.
    task automatic drive_to_stop(input logic [7:0] d, input logic stop_b);
        bus_if.serial_in = 1'b0;
        tick(BIT_CYCLES);
        for (int i = 0; i < 8; i++) begin
            bus_if.serial_in = d[i];
            tick(BIT_CYCLES);
        end
        bus_if.serial_in = stop_b;
        tick(STOP_SAMPLE - 9 * BIT_CYCLES);
    endtask

    initial begin
        bus_if.serial_in = 1'b1;
        bus_if.read      = 1'b0;

        // Reset values while reset is held.
        tick(3);
        check1("rst_full", bus_if.full, 1'b0);
        check8("rst_data", bus_if.parallel_out, 8'h00);
        check1("rst_ferr", bus_if.frame_err, 1'b0);
        check1("rst_ovr", bus_if.overrun, 1'b0);
        reset = 1'b0;
        tick(5);

        // read while empty is ignored.
        bus_if.read = 1'b1;
        tick(1);
        bus_if.read = 1'b0;
        tick(1);
        check1("empty_read_full", bus_if.full, 1'b0);
        check1("empty_read_ovr", bus_if.overrun, 1'b0);

        // 300-cycle low glitch: start detected, then aborted at the start sample.
        bus_if.serial_in = 1'b0;
        tick(300);
        check_st("glitch_start", START);
        bus_if.serial_in = 1'b1;
        tick(400);
        check_st("glitch_idle", IDLE);
        check1("glitch_full", bus_if.full, 1'b0);
        check1("glitch_ferr", bus_if.frame_err, 1'b0);

        // Byte A5: outputs change exactly one cycle after the stop sample.
        drive_to_stop(8'hA5, 1'b1);
        check1("a5_pre_full", bus_if.full, 1'b0);
        tick(1);
        check1("a5_full", bus_if.full, 1'b1);
        check8("a5_data", bus_if.parallel_out, 8'hA5);
        check1("a5_ferr", bus_if.frame_err, 1'b0);
        check1("a5_ovr", bus_if.overrun, 1'b0);
        tick(FRAME_REST);

        // Byte 22 back-to-back, read lands on its stop sample: no overrun.
        drive_to_stop(8'h22, 1'b1);
        check8("b22_pre_data", bus_if.parallel_out, 8'hA5);
        bus_if.read = 1'b1;
        tick(1);
        bus_if.read = 1'b0;
        check8("b22_data", bus_if.parallel_out, 8'h22);
        check1("b22_full", bus_if.full, 1'b1);
        check1("b22_ovr", bus_if.overrun, 1'b0);
        tick(FRAME_REST);

        // Byte 11 back-to-back with 22 unread: overwrite and overrun.
        drive_to_stop(8'h11, 1'b1);
        tick(1);
        check8("b11_data", bus_if.parallel_out, 8'h11);
        check1("b11_full", bus_if.full, 1'b1);
        check1("b11_ovr", bus_if.overrun, 1'b1);
        tick(FRAME_REST);

        // A read clears full and overrun in one cycle.
        bus_if.read = 1'b1;
        tick(1);
        bus_if.read = 1'b0;
        check1("rd_full", bus_if.full, 1'b0);
        check1("rd_ovr", bus_if.overrun, 1'b0);
        check8("rd_data", bus_if.parallel_out, 8'h11);
        tick(10);

        // Byte 3C with stop bit 0, then the line held low (break).
        drive_to_stop(8'h3C, 1'b0);
        check1("b3c_pre_ferr", bus_if.frame_err, 1'b0);
        tick(1);
        check1("b3c_ferr", bus_if.frame_err, 1'b1);
        check1("b3c_full", bus_if.full, 1'b0);
        check8("b3c_data", bus_if.parallel_out, 8'h11);
        tick(5000);
        check_st("brk_hold", BREAK);
        check1("brk_full", bus_if.full, 1'b0);
        check1("brk_ferr", bus_if.frame_err, 1'b1);
        bus_if.serial_in = 1'b1;
        tick(SYNC_LAT + 2);
        check_st("brk_release", IDLE);
        tick(20);

        // Byte FF interrupted by reset mid-frame.
        bus_if.serial_in = 1'b0;
        tick(BIT_CYCLES);
        bus_if.serial_in = 1'b1;
        tick(4 * BIT_CYCLES);
        check_st("ff_mid", DATA);
        reset = 1'b1;
        #1;
        check1("mid_rst_full", bus_if.full, 1'b0);
        check8("mid_rst_data", bus_if.parallel_out, 8'h00);
        check1("mid_rst_ferr", bus_if.frame_err, 1'b0);
        check_st("mid_rst_state", IDLE);
        tick(1);
        reset = 1'b0;
        tick(20);

        // Byte 55 received cleanly after reset release.
        drive_to_stop(8'h55, 1'b1);
        check1("b55_pre_full", bus_if.full, 1'b0);
        tick(1);
        check1("b55_full", bus_if.full, 1'b1);
        check8("b55_data", bus_if.parallel_out, 8'h55);
        check1("b55_ferr", bus_if.frame_err, 1'b0);
        check1("b55_ovr", bus_if.overrun, 1'b0);
        tick(FRAME_REST);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
